// File: rtl/sram_rr_arbiter.sv
// rtl/sram_rr_arbiter.sv - two-port round-robin arbiter and sequencer for a single-port byte-writable SRAM
module sram_rr_arbiter #(
    parameter int ADDRWIDTH = 16,
    parameter int DATAWIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RSTn,

    input  logic                 p0_req_valid,
    output logic                 p0_req_ready,
    input  logic [ADDRWIDTH-1:0] p0_req_addr,
    input  logic [3:0]           p0_req_we,
    input  logic [DATAWIDTH-1:0] p0_req_wdata,
    output logic                 p0_rsp_valid,
    input  logic                 p0_rsp_ready,
    output logic                 p0_rsp_write,
    output logic [DATAWIDTH-1:0] p0_rsp_rdata,

    input  logic                 p1_req_valid,
    output logic                 p1_req_ready,
    input  logic [ADDRWIDTH-1:0] p1_req_addr,
    input  logic [3:0]           p1_req_we,
    input  logic [DATAWIDTH-1:0] p1_req_wdata,
    output logic                 p1_rsp_valid,
    input  logic                 p1_rsp_ready,
    output logic                 p1_rsp_write,
    output logic [DATAWIDTH-1:0] p1_rsp_rdata,

    output logic                 sram_cs,
    output logic [3:0]           sram_we,
    output logic [ADDRWIDTH-1:0] sram_addr,
    output logic [DATAWIDTH-1:0] sram_wdata,
    input  logic [DATAWIDTH-1:0] sram_rdata
);

    // Per-port response holding registers
    logic                 r_pend0;
    logic                 r_pend1;
    logic                 r_rsp_write0;
    logic                 r_rsp_write1;
    logic [DATAWIDTH-1:0] r_rsp_rdata0;
    logic [DATAWIDTH-1:0] r_rsp_rdata1;

    // Port that wins when both are eligible
    logic                 r_rr_ptr;

    logic                 w_elig0;
    logic                 w_elig1;
    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_hs0;
    logic                 w_hs1;

    // Eligibility and grant; reset level blocks grants so the SRAM stays deselected in reset
    always_comb begin
        w_elig0  = RSTn & p0_req_valid & ~r_pend0;
        w_elig1  = RSTn & p1_req_valid & ~r_pend1;
        w_grant0 = w_elig0 & (~w_elig1 | ~r_rr_ptr);
        w_grant1 = w_elig1 & (~w_elig0 |  r_rr_ptr);
        w_hs0    = r_pend0 & p0_rsp_ready;
        w_hs1    = r_pend1 & p1_rsp_ready;
    end

    // SRAM access mux: the granted port drives the macro, idle cycles drive zeros
    always_comb begin
        sram_cs    = 1'b0;
        sram_we    = 4'h0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_grant0) begin
            sram_cs    = 1'b1;
            sram_we    = p0_req_we;
            sram_addr  = p0_req_addr;
            sram_wdata = p0_req_wdata;
        end else if (w_grant1) begin
            sram_cs    = 1'b1;
            sram_we    = p1_req_we;
            sram_addr  = p1_req_addr;
            sram_wdata = p1_req_wdata;
        end
    end

    // Round-robin pointer moves to the loser of each grant
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_grant1) begin
            r_rr_ptr <= 1'b0;
        end
    end

    // Port 0 response register: capture on grant, release on handshake
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pend0      <= 1'b0;
            r_rsp_write0 <= 1'b0;
            r_rsp_rdata0 <= '0;
        end else if (w_grant0) begin
            r_pend0      <= 1'b1;
            r_rsp_write0 <= |p0_req_we;
            r_rsp_rdata0 <= (|p0_req_we) ? '0 : sram_rdata;
        end else if (w_hs0) begin
            r_pend0      <= 1'b0;
        end
    end

    // Port 1 response register: capture on grant, release on handshake
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_pend1      <= 1'b0;
            r_rsp_write1 <= 1'b0;
            r_rsp_rdata1 <= '0;
        end else if (w_grant1) begin
            r_pend1      <= 1'b1;
            r_rsp_write1 <= |p1_req_we;
            r_rsp_rdata1 <= (|p1_req_we) ? '0 : sram_rdata;
        end else if (w_hs1) begin
            r_pend1      <= 1'b0;
        end
    end

    assign p0_req_ready = w_grant0;
    assign p1_req_ready = w_grant1;
    assign p0_rsp_valid = r_pend0;
    assign p1_rsp_valid = r_pend1;
    assign p0_rsp_write = r_rsp_write0;
    assign p1_rsp_write = r_rsp_write1;
    assign p0_rsp_rdata = r_rsp_rdata0;
    assign p1_rsp_rdata = r_rsp_rdata1;

endmodule
